mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM pipeline stage and data memory.
// The master issues a registered request and holds it until the slave strobes ack.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: single outstanding data-memory access with timeout.
// Stalls upstream while the access is in flight and produces the MEM/WB register.
module mem_stage #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  WB_mem,
   input  logic        M_mem,
   input  logic [31:0] ALUResult_mem,
   input  logic [31:0] MemWriteData_mem,
   input  logic [4:0]  rdAddr_mem,
   mem_stage_if.master dmem,
   output logic        stall,
   output logic [1:0]  WB_wb,
   output logic [31:0] ReadData_wb,
   output logic [31:0] ALUResult_wb,
   output logic [4:0]  rdAddr_wb,
   output logic        mem_err
);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        mem_err_q;
   logic        dmem_req_q;
   logic        dmem_we_q;
   logic [31:0] dmem_addr_q;
   logic [31:0] dmem_wdata_q;
   logic [1:0]  wb_wb_q;
   logic [31:0] read_data_wb_q;
   logic [31:0] alu_result_wb_q;
   logic [4:0]  rd_addr_wb_q;

   logic memop;
   assign memop = M_mem | WB_mem[0];

   // Gated by rst_n so the hold request is released while reset is asserted,
   // whatever the upstream stages are presenting.
   always_comb begin
      stall = 1'b0;
      if (rst_n) begin
         case (state_q)
            IDLE:    stall = memop;
            ACCESS:  stall = !dmem.dmem_ack && (cnt_q != LAST_CNT);
            default: stall = 1'b0;
         endcase
      end
   end

   // NOTE: every register in this block uses <= so all next-state values are
   // computed from the pre-edge state, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         mem_err_q       <= 1'b0;
         dmem_req_q      <= 1'b0;
         dmem_we_q       <= 1'b0;
         dmem_addr_q     <= '0;
         dmem_wdata_q    <= '0;
         wb_wb_q         <= '0;
         read_data_wb_q  <= '0;
         alu_result_wb_q <= '0;
         rd_addr_wb_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (memop) begin
                  state_q         <= ACCESS;
                  cnt_q           <= '0;
                  dmem_req_q      <= 1'b1;
                  dmem_we_q       <= M_mem;
                  dmem_addr_q     <= ALUResult_mem;
                  dmem_wdata_q    <= MemWriteData_mem;
                  wb_wb_q         <= '0;
                  read_data_wb_q  <= '0;
                  alu_result_wb_q <= '0;
                  rd_addr_wb_q    <= '0;
               end else begin
                  wb_wb_q         <= WB_mem;
                  read_data_wb_q  <= '0;
                  alu_result_wb_q <= ALUResult_mem;
                  rd_addr_wb_q    <= rdAddr_mem;
               end
            end
            ACCESS: begin
               if (dmem.dmem_ack) begin
                  // Ack wins over a simultaneous timeout; the latched we decides load vs store.
                  state_q         <= IDLE;
                  dmem_req_q      <= 1'b0;
                  wb_wb_q         <= WB_mem;
                  read_data_wb_q  <= dmem_we_q ? 32'h0 : dmem.dmem_rdata;
                  alu_result_wb_q <= ALUResult_mem;
                  rd_addr_wb_q    <= rdAddr_mem;
               end else if (cnt_q == LAST_CNT) begin
                  state_q         <= IDLE;
                  dmem_req_q      <= 1'b0;
                  mem_err_q       <= 1'b1;
                  wb_wb_q         <= '0;
                  read_data_wb_q  <= '0;
                  alu_result_wb_q <= ALUResult_mem;
                  rd_addr_wb_q    <= rdAddr_mem;
               end else begin
                  cnt_q           <= cnt_q + 8'd1;
                  wb_wb_q         <= '0;
                  read_data_wb_q  <= '0;
                  alu_result_wb_q <= '0;
                  rd_addr_wb_q    <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem.dmem_req   = dmem_req_q;
   assign dmem.dmem_we    = dmem_we_q;
   assign dmem.dmem_addr  = dmem_addr_q;
   assign dmem.dmem_wdata = dmem_wdata_q;

   assign WB_wb        = wb_wb_q;
   assign ReadData_wb  = read_data_wb_q;
   assign ALUResult_wb = alu_result_wb_q;
   assign rdAddr_wb    = rd_addr_wb_q;
   assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage: the driver issues instructions and queues
// the expected MEM/WB result, a memory responder acks after a chosen delay, a monitor checks.
module tb_mem_stage;
   localparam int MAX_WAIT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  WB_mem;
   logic        M_mem;
   logic [31:0] ALUResult_mem;
   logic [31:0] MemWriteData_mem;
   logic [4:0]  rdAddr_mem;
   logic        stall;
   logic [1:0]  WB_wb;
   logic [31:0] ReadData_wb;
   logic [31:0] ALUResult_wb;
   logic [4:0]  rdAddr_wb;
   logic        mem_err;

   mem_stage_if bus ();

   mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .WB_mem           (WB_mem),
      .M_mem            (M_mem),
      .ALUResult_mem    (ALUResult_mem),
      .MemWriteData_mem (MemWriteData_mem),
      .rdAddr_mem       (rdAddr_mem),
      .dmem             (bus.master),
      .stall            (stall),
      .WB_wb            (WB_wb),
      .ReadData_wb      (ReadData_wb),
      .ALUResult_wb     (ALUResult_wb),
      .rdAddr_wb        (rdAddr_wb),
      .mem_err          (mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  wb;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic        mon_en = 1'b0;
   logic        model_err = 1'b0;
   int          ack_at = 0;
   logic        exp_we = 1'b0;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_wdata = '0;
   logic [31:0] mem_rdata = '0;
   int          req_cnt = 0;
   int          req_len = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory model: acks on the ack_at-th request cycle (0 = never), random ack noise when idle.
   always @(posedge clk) begin
      #1;
      if (bus.dmem_req === 1'b1) begin
         req_cnt++;
         req_len = req_cnt;
         check("dmem_we", bus.dmem_we, exp_we);
         check("dmem_addr", bus.dmem_addr, exp_addr);
         check("dmem_wdata", bus.dmem_wdata, exp_wdata);
         bus.dmem_ack   = (req_cnt == ack_at);
         bus.dmem_rdata = mem_rdata;
      end else begin
         req_cnt        = 0;
         bus.dmem_ack   = 1'($urandom_range(0, 1));
         bus.dmem_rdata = $urandom;
      end
   end

   // Every issued instruction has rd != 0, so any non-zero MEM/WB word is a retired result.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && mon_en) begin
         if ({WB_wb, ReadData_wb, ALUResult_wb, rdAddr_wb} != '0) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_retire: got rd=%0d alu=%0h expected no result", rdAddr_wb, ALUResult_wb);
            end else begin
               e = sb.pop_front();
               check("WB_wb", 32'(WB_wb), 32'(e.wb));
               check("ReadData_wb", ReadData_wb, e.rdata);
               check("ALUResult_wb", ALUResult_wb, e.alu);
               check("rdAddr_wb", 32'(rdAddr_wb), 32'(e.rd));
               check("mem_err", 32'(mem_err), 32'(e.err));
            end
         end
      end
   end

   task automatic drive_nop();
      WB_mem = 2'b00; M_mem = 1'b0; ALUResult_mem = '0; MemWriteData_mem = '0; rdAddr_mem = '0;
   endtask

   // Called at posedge+2; returns at posedge+2 after the instruction has been accepted.
   task automatic issue(input logic [1:0] wb, input logic m, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rd, input int ack,
                        input logic [31:0] rdata);
      exp_t e;
      int   cycles;
      int   n;
      logic memop;
      logic timed_out;
      memop     = m | wb[0];
      timed_out = memop && (ack < 1 || ack > MAX_WAIT);
      WB_mem = wb; M_mem = m; ALUResult_mem = alu; MemWriteData_mem = wd; rdAddr_mem = rd;
      ack_at = ack; exp_we = m; exp_addr = alu; exp_wdata = wd; mem_rdata = rdata; req_len = 0;
      if (!memop)        cycles = 0;
      else if (timed_out) cycles = MAX_WAIT;
      else               cycles = ack;
      e.alu = alu;
      e.rd  = rd;
      if (!memop) begin
         e.wb = wb; e.rdata = '0;
      end else if (timed_out) begin
         e.wb = 2'b00; e.rdata = '0; model_err = 1'b1;
      end else begin
         e.wb = wb; e.rdata = m ? 32'h0 : rdata;
      end
      e.err = model_err;
      sb.push_back(e);
      n = 0;
      @(negedge clk);
      while (stall && n <= MAX_WAIT + 4) begin
         n++;
         @(negedge clk);
      end
      check("stall_cycles", 32'(n), 32'(cycles));
      @(posedge clk);
      #2;
      if (memop) begin
         check("req_cycles", 32'(req_len), 32'(cycles));
         check("req_dropped", 32'(bus.dmem_req), 32'h0);
      end
      drive_nop();
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] wb;
      logic       m;
      int         kind;
      int         ack;

      // Memop presented during reset must not raise stall.
      WB_mem = 2'b11; M_mem = 1'b1; ALUResult_mem = 32'hFFFF_0000; MemWriteData_mem = 32'h1;
      rdAddr_mem = 5'd3;
      bus.dmem_ack = 1'b1; bus.dmem_rdata = '0;
      #12;
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_req", 32'(bus.dmem_req), 32'h0);
      check("rst_we", 32'(bus.dmem_we), 32'h0);
      check("rst_addr", bus.dmem_addr, 32'h0);
      check("rst_wdata", bus.dmem_wdata, 32'h0);
      check("rst_WB_wb", 32'(WB_wb), 32'h0);
      check("rst_ReadData", ReadData_wb, 32'h0);
      check("rst_ALUResult", ALUResult_wb, 32'h0);
      check("rst_rdAddr", 32'(rdAddr_wb), 32'h0);
      check("rst_mem_err", 32'(mem_err), 32'h0);
      drive_nop();
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #2;

      issue(2'b10, 1'b0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
      issue(2'b11, 1'b0, 32'h100, 32'h0, 5'd7, 1, 32'hDEADBEEF);
      issue(2'b00, 1'b1, 32'h200, 32'hA5A5A5A5, 5'd9, 3, 32'h0BAD_F00D);
      issue(2'b11, 1'b0, 32'h300, 32'h0, 5'd10, MAX_WAIT, 32'h1357_9BDF);
      issue(2'b11, 1'b0, 32'h400, 32'h0, 5'd11, 0, 32'h2468_ACE0);
      issue(2'b10, 1'b0, 32'h55, 32'h0, 5'd12, 0, 32'h0);
      // Both MemWrite and MemtoReg set: treated as a store, ReadData_wb stays 0.
      issue(2'b11, 1'b1, 32'h600, 32'h7777_0000, 5'd13, 2, 32'hFFFF_FFFF);

      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 2);
         case (kind)
            0:       begin wb = {1'($urandom_range(0, 1)), 1'b0}; m = 1'b0; end
            1:       begin wb = {1'($urandom_range(0, 1)), 1'b1}; m = 1'b0; end
            default: begin wb = 2'($urandom_range(0, 3));        m = 1'b1; end
         endcase
         ack = $urandom_range(0, MAX_WAIT + 2);
         issue(wb, m, $urandom, $urandom, 5'($urandom_range(1, 31)), ack, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #2;
         end
      end

      // Reset in the second ACCESS cycle of a load: request must drop with no clock edge.
      WB_mem = 2'b11; M_mem = 1'b0; ALUResult_mem = 32'h500; MemWriteData_mem = '0; rdAddr_mem = 5'd14;
      ack_at = 0; exp_we = 1'b0; exp_addr = 32'h500; exp_wdata = '0; mem_rdata = 32'hCAFE_0001;
      @(posedge clk);
      @(posedge clk);
      #3;
      check("access_req", 32'(bus.dmem_req), 32'h1);
      rst_n = 1'b0;
      #1;
      check("async_req_drop", 32'(bus.dmem_req), 32'h0);
      check("async_stall", 32'(stall), 32'h0);
      check("async_WB_wb", 32'(WB_wb), 32'h0);
      check("async_ALUResult", ALUResult_wb, 32'h0);
      check("async_rdAddr", 32'(rdAddr_wb), 32'h0);
      check("async_mem_err", 32'(mem_err), 32'h0);
      model_err = 1'b0;
      drive_nop();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      issue(2'b10, 1'b0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
